// File: rtl/imm_extend_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe_if
// Handshake bundle between the decode stage, the immediate-extension unit and
// the execute-stage operand muxes.
//
// Signals:
//   in_valid  / in_ready   input item handshake (decode -> extender)
//   in_data   [IN_W]       raw immediate field
//   in_mode   [2]          00 zero, 01 sign, 10 upper (LUI), 11 branch offset
//   in_tag    [TAG_W]      sideband tag (destination register index)
//   out_valid / out_ready  result handshake (extender -> execute)
//   out_data  [OUT_W]      extended immediate
//   out_tag   [TAG_W]      tag travelling with the result
//   out_mode  [2]          mode travelling with the result
//
// Modports:
//   master  the environment side: produces input items, consumes results
//   slave   the extension unit itself
// ---------------------------------------------------------------------------
interface imm_extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_mode;

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_tag,
    input  out_mode
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  in_tag,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_tag,
    output out_mode
  );

endinterface

// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
// Pipelined immediate-extension unit for the MIPS datapath. Widens an IN_W-bit
// immediate to OUT_W bits (zero-extend, sign-extend, LUI placement, or
// sign-extend-and-shift-by-2 for branch offsets) and hands the result to the
// execute stage over a valid/ready handshake.
//
// The result sits in an output register (OR). A one-entry skid register (SK)
// catches the item that arrives while OR is stalled, which lets in_ready be a
// plain flop (!SK.valid) instead of a combinational function of out_ready.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   flush       synchronous flush: drops OR and SK, discards the input of
//               the same cycle
//   bus         imm_extend_pipe_if.slave handshake bundle (input item and
//               result with tag/mode sideband)
//   stat_count  16-bit saturating count of accepted items
//
// Build option:
//   IMM_EXTEND_STATS_EN  when defined, stat_count is a real saturating counter
//                        cleared only by reset; when undefined stat_count is
//                        tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  imm_extend_pipe_if.slave    bus,
  output logic [15:0]         stat_count
);

  // Extension mode encodings
  localparam logic [1:0] MODE_ZERO   = 2'b00;
  localparam logic [1:0] MODE_SIGN   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // A narrower output than input has no meaningful extension; refuse to build.
  generate
    if (OUT_W < IN_W) begin : g_bad_width
      $error("imm_extend_pipe: OUT_W (%0d) must be >= IN_W (%0d)", OUT_W, IN_W);
    end
  endgenerate

  // Output register (OR)
  logic             r_or_valid;
  logic [OUT_W-1:0] r_or_data;
  logic [TAG_W-1:0] r_or_tag;
  logic [1:0]       r_or_mode;

  // Skid register (SK)
  logic             r_sk_valid;
  logic [OUT_W-1:0] r_sk_data;
  logic [TAG_W-1:0] r_sk_tag;
  logic [1:0]       r_sk_mode;

  logic             r_in_ready;

  logic [OUT_W-1:0] w_ext_data;
  logic             w_in_xfer;
  logic             w_or_drain;
  logic             w_or_free;

  assign w_in_xfer  = bus.in_valid && r_in_ready;
  assign w_or_drain = r_or_valid && bus.out_ready;
  // OR can take a new item this edge if it is empty or being emptied now.
  assign w_or_free  = !r_or_valid || bus.out_ready;

  // The size casts handle OUT_W == IN_W without a zero-width replication;
  // casting the $signed operand sign-extends.
  always_comb begin
    w_ext_data = '0;
    case (bus.in_mode)
      MODE_ZERO:   w_ext_data = OUT_W'(bus.in_data);
      MODE_SIGN:   w_ext_data = OUT_W'($signed(bus.in_data));
      MODE_UPPER:  w_ext_data = OUT_W'(bus.in_data) << (OUT_W - IN_W);
      MODE_BRANCH: w_ext_data = OUT_W'($signed(bus.in_data)) << 2;
      default:     w_ext_data = '0;
    endcase
  end

  // OR / SK control. Flush has priority over everything except reset.
  // SK full means in_ready is low, so no input can arrive in that branch.
  // in_ready comes out of reset low and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_or_valid <= 1'b0;
      r_or_data  <= '0;
      r_or_tag   <= '0;
      r_or_mode  <= '0;
      r_sk_valid <= 1'b0;
      r_sk_data  <= '0;
      r_sk_tag   <= '0;
      r_sk_mode  <= '0;
      r_in_ready <= 1'b0;
    end else if (flush) begin
      r_or_valid <= 1'b0;
      r_sk_valid <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (r_sk_valid) begin
      if (w_or_drain) begin
        r_or_data  <= r_sk_data;
        r_or_tag   <= r_sk_tag;
        r_or_mode  <= r_sk_mode;
        r_sk_valid <= 1'b0;
        r_in_ready <= 1'b1;
      end
    end else begin
      r_in_ready <= 1'b1;
      if (w_in_xfer) begin
        if (w_or_free) begin
          r_or_valid <= 1'b1;
          r_or_data  <= w_ext_data;
          r_or_tag   <= bus.in_tag;
          r_or_mode  <= bus.in_mode;
        end else begin
          r_sk_valid <= 1'b1;
          r_sk_data  <= w_ext_data;
          r_sk_tag   <= bus.in_tag;
          r_sk_mode  <= bus.in_mode;
          r_in_ready <= 1'b0;
        end
      end else if (w_or_drain) begin
        r_or_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_or_valid;
  assign bus.out_data  = r_or_data;
  assign bus.out_tag   = r_or_tag;
  assign bus.out_mode  = r_or_mode;

`ifdef IMM_EXTEND_STATS_EN
  logic [15:0] r_stat_count;

  // Counts accepted inputs; a transfer coinciding with flush is discarded
  // and so is not counted. Saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_count <= 16'h0000;
    end else if (w_in_xfer && !flush && (r_stat_count != 16'hFFFF)) begin
      r_stat_count <= r_stat_count + 16'd1;
    end
  end

  assign stat_count = r_stat_count;
`else
  assign stat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
// Directed bench for imm_extend_pipe: reset values, each extension mode,
// skid/backpressure ordering, flush, asynchronous reset, the optional
// statistics counter, and a randomised handshake run against a queue model.
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] statCount;

  int checks   = 0;
  int failures = 0;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32), .TAG_W(5)) bus ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .bus        (bus),
    .stat_count (statCount)
  );

  always #5 clk = ~clk;

  // Directed extension vectors with hand-computed results
  logic [1:0]  vMode [9] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b11,
                             2'b11, 2'b00, 2'b10, 2'b01};
  logic [15:0] vData [9] = '{16'h7FFF, 16'h8001, 16'h1234, 16'hFFFF, 16'h0001,
                             16'h7FFF, 16'hFFFF, 16'hFFFF, 16'h8000};
  logic [31:0] vExp  [9] = '{32'h00007FFF, 32'h00008001, 32'h12340000,
                             32'hFFFFFFFC, 32'h00000004, 32'h0001FFFC,
                             32'h0000FFFF, 32'hFFFF0000, 32'hFFFF8000};

  // Counts one comparison and reports it if the values differ
  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  // Drives the input side of the handshake
  task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                               input logic [15:0] data, input logic [4:0] tag);
    bus.in_valid = valid;
    bus.in_mode  = mode;
    bus.in_data  = data;
    bus.in_tag   = tag;
  endtask

  // Advances one clock; everything is driven and sampled 1 unit after the edge
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
  endtask

  // Expected statistics value for n accepted items under the current build
  function automatic logic [15:0] expStat(input int n);
`ifdef IMM_EXTEND_STATS_EN
    return 16'(n);
`else
    return 16'h0000;
`endif
  endfunction

  // Independent reference of the 16->32 extension
  function automatic logic [31:0] modelExt(input logic [1:0] mode, input logic [15:0] d);
    case (mode)
      2'b00:   return {16'h0000, d};
      2'b01:   return {{16{d[15]}}, d};
      2'b10:   return {d, 16'h0000};
      default: return {{14{d[15]}}, d, 2'b00};
    endcase
  endfunction

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [38:0] scoreQ[$];
    logic [38:0] expItem;
    int sent;
    int recv;
    int cyc;

    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);

    // Reset values
    #23;
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data",  64'(bus.out_data),  64'd0);
    checkOutput("rst_out_tag",   64'(bus.out_tag),   64'd0);
    checkOutput("rst_out_mode",  64'(bus.out_mode),  64'd0);
    checkOutput("rst_stat",      64'(statCount),     64'd0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);

    // Sign-extend, single item, one-cycle latency, valid for exactly one cycle
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 2'b01, 16'h8001, 5'd3);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    checkOutput("sign_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("sign_data",  64'(bus.out_data),  64'hFFFF8001);
    checkOutput("sign_tag",   64'(bus.out_tag),   64'd3);
    checkOutput("sign_mode",  64'(bus.out_mode),  64'd1);
    stepCycle();
    checkOutput("sign_onecycle", 64'(bus.out_valid), 64'd0);

    // Back-to-back mode vectors with the consumer always ready
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, vMode[i], vData[i], 5'(i + 8));
      stepCycle();
      checkOutput("vec_valid", 64'(bus.out_valid), 64'd1);
      checkOutput("vec_data",  64'(bus.out_data),  64'(vExp[i]));
      checkOutput("vec_tag",   64'(bus.out_tag),   64'(i + 8));
      checkOutput("vec_mode",  64'(bus.out_mode),  64'(vMode[i]));
    end
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    stepCycle();
    checkOutput("vec_idle", 64'(bus.out_valid), 64'd0);

    // Backpressure: tags 1,2 accepted, 3 held off, then drained in order
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 16'h0011, 5'd1);
    stepCycle();
    checkOutput("bp1_in_ready", 64'(bus.in_ready), 64'd1);
    checkOutput("bp1_tag",      64'(bus.out_tag),  64'd1);
    applyStimulus(1'b1, 2'b00, 16'h0022, 5'd2);
    stepCycle();
    checkOutput("bp2_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("bp2_tag",      64'(bus.out_tag),  64'd1);
    applyStimulus(1'b1, 2'b00, 16'h0033, 5'd3);
    stepCycle();
    checkOutput("bp3_in_ready", 64'(bus.in_ready), 64'd0);
    checkOutput("bp3_hold_tag", 64'(bus.out_tag),  64'd1);
    checkOutput("bp3_hold_dat", 64'(bus.out_data), 64'h11);
    bus.out_ready = 1'b1;
    stepCycle();
    checkOutput("bp4_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp4_tag",   64'(bus.out_tag),   64'd2);
    checkOutput("bp4_data",  64'(bus.out_data),  64'h22);
    checkOutput("bp4_ready", 64'(bus.in_ready),  64'd1);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    checkOutput("bp5_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("bp5_tag",   64'(bus.out_tag),   64'd3);
    checkOutput("bp5_data",  64'(bus.out_data),  64'h33);
    stepCycle();
    checkOutput("bp6_empty", 64'(bus.out_valid), 64'd0);

    // Random handshake against a queue model
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 1000 && cyc < 20000) begin
      if (sent < 1000 && $urandom_range(0, 3) != 0)
        applyStimulus(1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 5'($urandom));
      else
        applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.in_valid && bus.in_ready) begin
        scoreQ.push_back({modelExt(bus.in_mode, bus.in_data), bus.in_tag, bus.in_mode});
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (scoreQ.size() == 0) begin
          checkOutput("rnd_unexpected", 64'd1, 64'd0);
        end else begin
          expItem = scoreQ.pop_front();
          checkOutput("rnd_item", 64'({bus.out_data, bus.out_tag, bus.out_mode}), 64'(expItem));
        end
        recv++;
      end
      stepCycle();
      cyc++;
    end
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    checkOutput("rnd_count",    64'(recv),          64'd1000);
    checkOutput("rnd_leftover", 64'(scoreQ.size()), 64'd0);

    // Flush with OR and SK full, then flush against an acceptable input
    doReset();
    checkOutput("fl_rst_stat", 64'(statCount), 64'(expStat(0)));
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 16'h0044, 5'd4);
    stepCycle();
    applyStimulus(1'b1, 2'b00, 16'h0055, 5'd5);
    stepCycle();
    checkOutput("fl_full_ready", 64'(bus.in_ready), 64'd0);
    applyStimulus(1'b1, 2'b00, 16'h0066, 5'd6);
    flush = 1'b1;
    stepCycle();
    checkOutput("fl1_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("fl1_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("fl1_stat",  64'(statCount),     64'(expStat(2)));
    applyStimulus(1'b1, 2'b00, 16'h0077, 5'd7);
    stepCycle();
    checkOutput("fl2_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("fl2_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("fl2_stat",  64'(statCount),     64'(expStat(2)));
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 2'b00, 16'h0088, 5'd8);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    checkOutput("fl3_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("fl3_tag",   64'(bus.out_tag),   64'd8);
    checkOutput("fl3_data",  64'(bus.out_data),  64'h88);
    checkOutput("fl3_stat",  64'(statCount),     64'(expStat(3)));
    stepCycle();
    checkOutput("fl4_empty", 64'(bus.out_valid), 64'd0);

    // Statistics over five items, then asynchronous reset with items in flight
    doReset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b01, 16'(16'h0100 + i), 5'(i + 10));
      stepCycle();
    end
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    stepCycle();
    checkOutput("st_count5", 64'(statCount), 64'(expStat(5)));
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 2'b00, 16'h0020, 5'd20);
    stepCycle();
    applyStimulus(1'b1, 2'b00, 16'h0021, 5'd21);
    stepCycle();
    applyStimulus(1'b0, 2'b00, 16'h0000, 5'd0);
    checkOutput("ar_inflight", 64'(bus.out_valid), 64'd1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("ar_data",  64'(bus.out_data),  64'd0);
    checkOutput("ar_stat",  64'(statCount),     64'd0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("ar_post_ready", 64'(bus.in_ready),  64'd1);
    checkOutput("ar_post_valid", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
